// File: rtl/region_burst_master_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// region_pkg : shared region codes, select-field position and FSM states
// Revision   : 1.0
// ----------------------------------------------------------------------------
package region_pkg;

  localparam logic [2:0] REGION_CODE0 = 3'b001;
  localparam logic [2:0] REGION_CODE1 = 3'b010;
  localparam logic [2:0] REGION_CODE2 = 3'b011;
  localparam logic [2:0] REGION_CODE3 = 3'b100;

  localparam int REGION_SEL_LSB = 16;
  localparam int REGION_SEL_MSB = 18;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Build a bus address: region code in the select field, offset below it.
  function automatic logic [31:0] region_addr(input logic [2:0]  code,
                                              input logic [15:0] offset);
    logic [31:0] addr;
    addr = '0;
    addr[REGION_SEL_MSB:REGION_SEL_LSB] = code;
    addr[REGION_SEL_LSB-1:0]            = offset;
    return addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/region_burst_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// region_burst_if : command and address-bus signals of the burst master
// Revision        : 1.0
// ----------------------------------------------------------------------------
interface region_burst_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_region;
  logic [15:0]      cmd_offset;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      a;
  logic             a_valid;
  logic [3:0]       ack;
  logic             done;
  logic             err;

  modport master (
    input  cmd_valid, cmd_region, cmd_offset, cmd_len, ack,
    output cmd_ready, a, a_valid, done, err
  );

  modport slave (
    output cmd_valid, cmd_region, cmd_offset, cmd_len, ack,
    input  cmd_ready, a, a_valid, done, err
  );
endinterface
`default_nettype wire

// File: rtl/region_burst_master_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// region_encoder : 2-bit region id to 3-bit chip-select field code
// Revision       : 1.0
// ----------------------------------------------------------------------------
module region_encoder
  import region_pkg::*;
(
  input  logic [1:0] region_i,
  output logic [2:0] code_o
);

  always_comb begin
    code_o = REGION_CODE0;
    case (region_i)
      2'd0: code_o = REGION_CODE0;
      2'd1: code_o = REGION_CODE1;
      2'd2: code_o = REGION_CODE2;
      2'd3: code_o = REGION_CODE3;
      default: code_o = REGION_CODE0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/region_burst_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// region_burst_master : issues one region-encoded address per acknowledged beat
// Revision            : 1.0
// ----------------------------------------------------------------------------
module region_burst_master
  import region_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  region_burst_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [1:0]       region_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]      a_q;
  logic             a_valid_q;
  logic             cmd_ready_q;
  logic             done_q;
  logic             err_q;

  logic [2:0]       w_code;
  logic             w_ack;

  region_encoder u_encoder (
    .region_i (bus.cmd_region),
    .code_o   (w_code)
  );

  // Only the addressed region's acknowledge can complete a beat.
  assign w_ack = bus.ack[region_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      region_q    <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      a_q         <= '0;
      a_valid_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            region_q    <= bus.cmd_region;
            len_q       <= bus.cmd_len;
            beat_q      <= '0;
            wait_q      <= '0;
            a_q         <= region_addr(w_code, bus.cmd_offset);
            a_valid_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (w_ack) begin
            if (beat_q == len_q) begin
              a_q         <= '0;
              a_valid_q   <= 1'b0;
              cmd_ready_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else begin
              // Offset wraps within 16 bits; the region field is untouched.
              a_q[15:0] <= a_q[15:0] + 16'd1;
              beat_q    <= beat_q + LEN_W'(1);
              wait_q    <= '0;
            end
          end else if (wait_q == WAIT_LAST) begin
            a_q         <= '0;
            a_valid_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= IDLE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire
